// File: rtl/arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package arb_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;

  // Read data returned to a requester whose access was abandoned by the timeout.
  localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Wait-cycle counter for the arbiter's optional memory timeout.
// Present only when ARB_TIMEOUT_EN is defined; the default build has no counter.
`ifdef ARB_TIMEOUT_EN
module arb_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic n_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_hit
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // Count ack-less wait cycles; cleared whenever no access is outstanding.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Hit on the LIMIT-th consecutive wait cycle, so the access is abandoned
  // after exactly LIMIT cycles of mem_req without mem_ack.
  assign o_hit = i_enable && (r_cnt == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store requests onto one memory port.
// Data requests win over fetches; each transaction ends with a one-cycle ready.
// Optional feature macro: ARB_TIMEOUT_EN (abort after TIMEOUT_CYCLES without mem_ack).
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = ARB_ADDR_W,
  parameter int unsigned DATA_W         = ARB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              w_abort;
  logic              w_waiting;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_ready;
  logic              r_d_ready;
  logic              r_err;

  assign w_waiting = (r_state == FETCH) || (r_state == DATA);

`ifdef ARB_TIMEOUT_EN
  arb_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .n_reset (n_reset),
    .i_clear (!w_waiting),
    .i_enable(w_waiting && !mem_ack),
    .o_hit   (w_abort)
  );
`else
  assign w_abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: data beats fetch in IDLE; RESP always lasts one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (d_req) begin
          w_next = DATA;
        end else if (if_req) begin
          w_next = FETCH;
        end
      end
      FETCH, DATA: begin
        if (mem_ack || w_abort) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Memory-side request latching and requester-side response capture.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (d_req) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
          end else if (if_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= if_addr;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            r_mem_req  <= 1'b0;
            r_if_rdata <= mem_rdata;
            r_if_ready <= 1'b1;
          end else if (w_abort) begin
            r_mem_req  <= 1'b0;
            r_if_rdata <= DATA_W'(ARB_ABORT_DATA);
            r_if_ready <= 1'b1;
            r_err      <= 1'b1;
          end
        end
        DATA: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_d_rdata <= mem_rdata;
            r_d_ready <= 1'b1;
          end else if (w_abort) begin
            r_mem_req <= 1'b0;
            r_d_rdata <= DATA_W'(ARB_ABORT_DATA);
            r_d_ready <= 1'b1;
            r_err     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_ready  = r_if_ready;
  assign d_ready   = r_d_ready;
  assign busy      = (r_state != IDLE);
  assign err       = r_err;

endmodule
